// File: rtl/gf2n_power_seq_if.sv
// Handshake bundle for gf2n_power_seq: operand channel (x, e) and result channel.
interface gf2n_power_seq_if #(
    parameter int N     = 6,
    parameter int EXP_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;

    // Operand source / result sink side
    modport master (
        output in_valid,
        output in_data,
        output in_exp,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Power-map engine side
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_exp,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/gf2n_power_seq.sv
// Sequential power-map engine: y = x^e in GF(2^N), polynomial basis given by POLY.
// Constant-time MSB-first square-and-multiply, one iteration per clock, EXP_W
// iterations per operand, behind a valid/ready handshake.
module gf2n_power_seq #(
    parameter int         N     = 6,
    parameter logic [N:0] POLY  = 7'h43,
    parameter int         EXP_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    gf2n_power_seq_if.slave   bus,
    output logic              busy
);

    localparam int         CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // A polynomial without the x^N or x^0 term is not a valid field modulus.
    if (POLY[N] == 1'b0 || POLY[0] == 1'b0) begin : g_bad_poly
        $error("gf2n_power_seq: POLY must have bits N and 0 set");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [N-1:0]     acc;
    logic [N-1:0]     base;
    logic [EXP_W-1:0] exp_r;
    logic [CNT_W-1:0] cnt;
    logic             out_valid_r;
    logic [N-1:0]     out_data_r;
    logic             busy_r;

    logic             in_ready_w;
    logic             accept;
    logic [N-1:0]     sq;
    logic [N-1:0]     mul_op;
    logic [N-1:0]     acc_nxt;

    // Multiply by alpha, reducing the overflow term with POLY.
    function automatic logic [N-1:0] xtime(input logic [N-1:0] a);
        logic [N-1:0] t;
        t = a << 1;
        if (a[N-1]) begin
            t = t ^ POLY[N-1:0];
        end
        return t;
    endfunction

    // Shift-and-reduce field multiply: accumulate a*alpha^i for each set bit of b.
    function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] p;
        logic [N-1:0] t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < N; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end
            t = xtime(t);
        end
        return p;
    endfunction

    assign in_ready_w    = (state == IDLE) | ((state == DONE) & bus.out_ready);
    assign accept        = bus.in_valid & in_ready_w;
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign busy          = busy_r;

    // One square-and-multiply step: acc^2 * (current exponent bit ? base : 1).
    always_comb begin
        sq      = gf_mul(acc, acc);
        mul_op  = exp_r[cnt] ? base : ONE;
        acc_nxt = gf_mul(sq, mul_op);
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            base        <= '0;
            exp_r       <= '0;
            cnt         <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    acc <= acc_nxt;
                    if (cnt == '0) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        out_data_r  <= acc_nxt;
                        busy_r      <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IDLE, DONE: begin
                    // Retire first; a same-edge accept below overrides the IDLE target.
                    if (state == DONE && bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                    if (accept) begin
                        base   <= bus.in_data;
                        exp_r  <= bus.in_exp;
                        acc    <= ONE;
                        cnt    <= CNT_W'(EXP_W - 1);
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
